// File: rtl/vga_sync_timing.sv
// VGA sync/blanking timing stage.
// Decodes the free-running XY pixel counters into registered sync, blanking,
// line/frame strobes, a frame counter and the vertical phase. Every output is
// registered, so all of them lag the counters by exactly one pixel clock and
// stay aligned with the delayed PixelX/PixelY coordinates.
module vga_sync_timing #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 720,
  parameter int unsigned H_SYNC_END   = 736,
  parameter int unsigned H_TOTAL      = 768,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 500,
  parameter int unsigned V_SYNC_END   = 502,
  parameter int unsigned V_TOTAL      = 512,
  parameter logic        SYNC_POL     = 1'b0,
  parameter int unsigned FRAME_W      = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [9:0]         CounterX,
  input  logic [8:0]         CounterY,
  output logic               HSync,
  output logic               VSync,
  output logic               DisplayOn,
  output logic [9:0]         PixelX,
  output logic [8:0]         PixelY,
  output logic               LineStart,
  output logic               FrameStart,
  output logic [FRAME_W-1:0] FrameCount,
  output logic [1:0]         VState
);

  // Vertical phase of the line currently being scanned.
  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYNC  = 2'd2,
    V_BACK  = 2'd3
  } vstate_e;

  // Timing constants sized to the counter widths so every compare is unsigned
  // at the input width. Vertical constants use 10 bits because the "next line"
  // value can momentarily reach V_TOTAL before it wraps.
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C     = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE_C     = 10'(H_SYNC_END);
  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C     = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE_C     = 10'(V_SYNC_END);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);

  logic               hsync_d, hsync_q;
  logic               vsync_d, vsync_q;
  logic               display_on_d, display_on_q;
  logic [9:0]         pixel_x_d, pixel_x_q;
  logic [8:0]         pixel_y_d, pixel_y_q;
  logic               line_start_d, line_start_q;
  logic               frame_start_d, frame_start_q;
  logic [FRAME_W-1:0] frame_count_d, frame_count_q;
  vstate_e            vstate_d, vstate_q;

  logic [9:0]         y_wide;
  logic [9:0]         next_line;
  vstate_e            next_phase;

  // Phase that the following line belongs to, with wrap after the last line.
  always_comb begin
    y_wide    = {1'b0, CounterY};
    next_line = y_wide + 10'd1;
    if (next_line >= V_TOTAL_C) begin
      next_line = 10'd0;
    end
    if (next_line < V_ACTIVE_C) begin
      next_phase = V_ACT;
    end else if (next_line < V_SS_C) begin
      next_phase = V_FRONT;
    end else if (next_line < V_SE_C) begin
      next_phase = V_SYNC;
    end else begin
      next_phase = V_BACK;
    end
  end

  // Decode the sampled counters into the next value of every registered output.
  always_comb begin
    hsync_d       = ((CounterX >= H_SS_C) && (CounterX < H_SE_C)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_wide >= V_SS_C) && (y_wide < V_SE_C)) ? SYNC_POL : ~SYNC_POL;
    display_on_d  = (CounterX < H_ACTIVE_C) && (y_wide < V_ACTIVE_C);
    pixel_x_d     = CounterX;
    pixel_y_d     = CounterY;
    line_start_d  = (CounterX == 10'd0);
    frame_start_d = (CounterX == 10'd0) && (CounterY == 9'd0);
    frame_count_d = frame_count_q;
    vstate_d      = vstate_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 1'b1;
      vstate_d      = V_ACT;
    end else if (CounterX == H_LAST_C) begin
      vstate_d      = next_phase;
    end
  end

  // Output registers; reset puts sync lines at their idle level and clears the rest.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      vstate_q      <= V_ACT;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      vstate_q      <= vstate_d;
    end
  end

  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign DisplayOn  = display_on_q;
  assign PixelX     = pixel_x_q;
  assign PixelY     = pixel_y_q;
  assign LineStart  = line_start_q;
  assign FrameStart = frame_start_q;
  assign FrameCount = frame_count_q;
  assign VState     = vstate_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Scoreboard bench for vga_sync_timing.
// A stimulus process drives counter values (directed sweeps plus random jumps)
// and pushes the expected registered outputs into a queue; an independent
// monitor pops one entry per clock and compares it with the DUT outputs.
module tb_vga_sync_timing;

   logic       Clk;
   logic       Rst_n;
   logic [9:0] CounterX;
   logic [8:0] CounterY;
   logic       HSync;
   logic       VSync;
   logic       DisplayOn;
   logic [9:0] PixelX;
   logic [8:0] PixelY;
   logic       LineStart;
   logic       FrameStart;
   logic [7:0] FrameCount;
   logic [1:0] VState;

   typedef struct {
      int hs;
      int vs;
      int disp;
      int px;
      int py;
      int ls;
      int fs;
      int fc;
      int vst;
   } expT;

   expT expQ[$];
   int  checks = 0;
   int  errors = 0;
   int  modelVs = 0;
   int  modelFc = 0;
   bit  stimDone = 0;

   vga_sync_timing dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .CounterX   (CounterX),
      .CounterY   (CounterY),
      .HSync      (HSync),
      .VSync      (VSync),
      .DisplayOn  (DisplayOn),
      .PixelX     (PixelX),
      .PixelY     (PixelY),
      .LineStart  (LineStart),
      .FrameStart (FrameStart),
      .FrameCount (FrameCount),
      .VState     (VState)
   );

   // Free-running pixel clock, 10 time units per period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Vertical phase a given line number belongs to, straight from the timing table.
   function automatic int phaseOf(int line);
      if (line < 480) return 0;
      if (line < 500) return 1;
      if (line < 502) return 2;
      return 3;
   endfunction

   // Compare one output field and log a failure line on mismatch.
   task automatic checkOutput(string name, int actual, int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at t=%0t actual=%0d expected=%0d", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the DUT must show after the next rising edge.
   task automatic applyStimulus(int x, int y, bit rstN);
      expT e;
      @(negedge Clk);
      Rst_n    = rstN;
      CounterX = 10'(x);
      CounterY = 9'(y);
      if (!rstN) begin
         modelVs = 0;
         modelFc = 0;
         e = '{hs: 1, vs: 1, disp: 0, px: 0, py: 0, ls: 0, fs: 0, fc: 0, vst: 0};
      end else begin
         e.hs   = (x >= 720 && x < 736) ? 0 : 1;
         e.vs   = (y >= 500 && y < 502) ? 0 : 1;
         e.disp = (x < 640 && y < 480) ? 1 : 0;
         e.px   = x;
         e.py   = y;
         e.ls   = (x == 0) ? 1 : 0;
         e.fs   = (x == 0 && y == 0) ? 1 : 0;
         if (e.fs == 1) begin
            modelFc = (modelFc + 1) % 256;
            modelVs = 0;
         end else if (x == 767) begin
            modelVs = phaseOf((y + 1) % 512);
         end
         e.fc  = modelFc;
         e.vst = modelVs;
      end
      expQ.push_back(e);
   endtask

   // Monitor: one output word per clock, sampled just after the rising edge.
   initial begin
      expT e;
      forever begin
         @(posedge Clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("HSync",      int'(HSync),      e.hs);
            checkOutput("VSync",      int'(VSync),      e.vs);
            checkOutput("DisplayOn",  int'(DisplayOn),  e.disp);
            checkOutput("PixelX",     int'(PixelX),     e.px);
            checkOutput("PixelY",     int'(PixelY),     e.py);
            checkOutput("LineStart",  int'(LineStart),  e.ls);
            checkOutput("FrameStart", int'(FrameStart), e.fs);
            checkOutput("FrameCount", int'(FrameCount), e.fc);
            checkOutput("VState",     int'(VState),     e.vst);
         end
      end
   end

   // Stimulus sequence: reset, directed sweeps, wrap, mid-frame reset, glitches, random.
   initial begin
      int coarseX[8] = '{0, 1, 639, 640, 720, 735, 736, 767};
      int x;
      int y;
      Rst_n    = 1'b0;
      CounterX = '0;
      CounterY = '0;

      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0);

      // First frame start straight out of reset.
      applyStimulus(0, 0, 1'b1);

      // One full line on Y=10.
      for (int i = 0; i < 768; i++) applyStimulus(i, 10, 1'b1);

      // A frame in coarse steps: the interesting X columns on every line.
      for (int l = 0; l < 512; l++) begin
         for (int k = 0; k < 8; k++) applyStimulus(coarseX[k], l, 1'b1);
      end

      // Enough frame starts to wrap the frame counter.
      for (int f = 0; f < 260; f++) begin
         applyStimulus(0, 0, 1'b1);
         applyStimulus(767, 511, 1'b1);
      end

      // Reset asserted mid-frame while the counters keep running.
      applyStimulus(300, 200, 1'b1);
      for (int i = 1; i <= 5; i++) applyStimulus(300 + i, 200, 1'b0);
      for (int i = 306; i < 768; i += 23) applyStimulus(i, 200, 1'b1);
      applyStimulus(767, 200, 1'b1);
      applyStimulus(0, 201, 1'b1);
      applyStimulus(767, 511, 1'b1);
      applyStimulus(0, 0, 1'b1);

      // Counter glitch from the front porch back to the origin.
      applyStimulus(767, 489, 1'b1);
      applyStimulus(5, 490, 1'b1);
      applyStimulus(0, 0, 1'b1);

      // Random jumps, including out-of-range X values and biased corner values.
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 5))
            0: x = 0;
            1: x = 767;
            2: x = $urandom_range(768, 1023);
            default: x = $urandom_range(0, 767);
         endcase
         y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 511);
         applyStimulus(x, y, 1'b1);
      end

      stimDone = 1;
   end

   // Drain the scoreboard with a bounded wait, then report.
   initial begin
      wait (stimDone);
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge Clk);
      #2;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain actual=%0d pending expected=0 pending", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
